lpc_ring_buf: RTL and testbench
===============================

LPC_RING_BUF -- requirements
Module: lpc_ring_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter SUB_LEN, default 40, meaning subframe length in samples.
REQ-003 SHALL have parameter FRAME_LEN, default 80, meaning frame length in samples; must equal 2*SUB_LEN.
REQ-004 SHALL have parameter WIN_LEN, default 240, meaning analysis window length in samples.
REQ-005 SHALL have parameter DEPTH, default 320, meaning buffer depth; must be a multiple of FRAME_LEN and at least WIN_LEN+FRAME_LEN.
REQ-006 SHALL have port clock, input, 1 bit, meaning the single clock (reset reset, synchronous, active-high; clock clock).
REQ-007 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit, meaning in_sample is written this cycle.
REQ-009 SHALL have port in_sample, input, DATA_W bits, meaning the pre-processed speech sample.
REQ-010 SHALL have port sub_done, output, 1 bit, meaning a one-cycle pulse at each subframe boundary.
REQ-011 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse when a frame completes and a new window is latched.
REQ-012 SHALL have port win_ready, output, 1 bit, meaning a latched window is available to the reader.
REQ-013 SHALL have port win_ack, input, 1 bit, meaning the reader releases the current window.
REQ-014 SHALL have port rd_req, input, 1 bit, meaning a read request.
REQ-015 SHALL have port rd_idx, input, clog2(WIN_LEN) bits, meaning the window-relative index, 0 being the oldest sample.
REQ-016 SHALL have port rd_valid, output, 1 bit, meaning rd_sample is valid.
REQ-017 SHALL have port rd_sample, output, DATA_W bits, meaning the read data.
REQ-018 SHALL have port overrun, output, 1 bit, meaning a sticky overrun flag, present only when LPC_RING_OVR_EN is defined.

Function
REQ-019 SHALL write in_sample to RAM[wptr] on each in_valid cycle and advance wptr modulo DEPTH using compare-and-clear, with no divider.
REQ-020 SHALL count accepted samples in cnt, 0..FRAME_LEN-1, wrapping to 0 after sample FRAME_LEN-1.
REQ-021 SHALL assert sub_done in the cycle after accepting a sample with cnt==SUB_LEN-1 or cnt==FRAME_LEN-1.
REQ-022 SHALL, in the cycle after accepting a sample with cnt==FRAME_LEN-1, assert frame_done, set win_ready, and latch win_base = (wptr_after - WIN_LEN) mod DEPTH, so the window covers the newest WIN_LEN samples.
REQ-023 SHALL maintain fill, saturating at WIN_LEN, incremented per accepted sample, and latch win_fill = fill at the same edge as win_base.
REQ-024 SHALL form the read address as win_base + rd_idx, subtracting DEPTH once when the sum is at least DEPTH.
REQ-025 SHALL, when rd_req=1 and win_ready=1 at cycle N, assert rd_valid and drive rd_sample at cycle N+1 (one-cycle latency), with back-to-back reads every cycle.
REQ-026 SHALL drive rd_sample=0 when rd_idx < WIN_LEN - win_fill (unwritten history); rd_idx >= WIN_LEN also reads 0.
REQ-027 SHALL hold rd_valid=0 in the next cycle when rd_req=1 and win_ready=0.
REQ-028 SHALL clear win_ready on the edge after win_ack=1; win_ack while win_ready=0 is ignored.
REQ-029 SHALL, on simultaneous win_ack and frame completion, leave win_ready=1 holding the new window, with no overrun.
REQ-030 SHALL, on frame completion while win_ready=1 without win_ack, replace the window with the newest one (win_base updates).
REQ-031 SHALL accept writes during reads; writes into the current window cannot occur before the next frame completes, given DEPTH >= WIN_LEN+FRAME_LEN.

Reset
REQ-032 SHALL, on reset, clear wptr, cnt, fill, win_base, win_fill, win_ready, sub_done, frame_done, rd_valid, rd_sample and overrun to 0 within one edge, including mid-frame or mid-read.
REQ-033 SHALL NOT clear RAM contents on reset; stale data is masked by fill=0 until rewritten.

Configuration
REQ-034 SHALL, with LPC_RING_OVR_EN defined, set overrun on the condition in REQ-030 and hold it until reset.
REQ-035 SHALL, with LPC_RING_OVR_EN undefined, omit the overrun port and logic; REQ-030 behaviour is unchanged.

Verification
REQ-036 SHALL cover: reset, then 80 in_valid samples of value k+1 (k=0..79) -> sub_done pulses after samples 40 and 80, frame_done after 80; reads idx 0..159 return 0 and idx 160..239 return 1..80.
REQ-037 SHALL cover: 4 frames with an ack each -> the 4th window idx 0 returns 81 and idx 239 returns 320; the write pointer wraps at 320.
REQ-038 SHALL cover: rd_req every cycle, idx 0..239 -> rd_valid continuous, with data one cycle behind idx.
REQ-039 SHALL cover: frame 2 completes with no win_ack -> overrun=1 (macro on), and window idx 239 = 160.
REQ-040 SHALL cover: win_ack on the same cycle as frame_done -> win_ready stays 1 and overrun stays 0.
REQ-041 SHALL cover: reset asserted at sample 37 -> all outputs 0, and the next frame_done occurs after 80 fresh samples.

Source files
------------

// File: rtl/lpc_ring_buf.sv
// -----------------------------------------------------------------------------
// lpc_ring_buf
//
// Circular sample buffer that feeds an LPC analysis stage. Incoming speech
// samples are written into a DEPTH-entry RAM. Every FRAME_LEN accepted samples
// a window of the newest WIN_LEN samples is latched (base pointer + fill
// count). A reader then fetches that window by window-relative index, with a
// one-cycle read latency.
//
// Optional feature: define LPC_RING_OVR_EN to add the sticky 'overrun' output.
// It is set when a new window replaces one the reader has not yet released.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   in_valid, in_sample  sample write strobe and data
//   sub_done             1-cycle pulse after each SUB_LEN-th sample of a frame
//   frame_done           1-cycle pulse when a frame completes (window latched)
//   win_ready            a latched window is available to the reader
//   win_ack              reader releases the current window
//   rd_req, rd_idx       read request, window-relative index (0 = oldest)
//   rd_valid, rd_sample  read response, one cycle after rd_req
//   overrun              sticky overrun flag (LPC_RING_OVR_EN only)
// -----------------------------------------------------------------------------
module lpc_ring_buf #(
    parameter int DATA_W    = 16,
    parameter int SUB_LEN   = 40,
    parameter int FRAME_LEN = 80,   // must equal 2*SUB_LEN
    parameter int WIN_LEN   = 240,
    parameter int DEPTH     = 320   // multiple of FRAME_LEN, >= WIN_LEN+FRAME_LEN
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_sample,
    output logic                       sub_done,
    output logic                       frame_done,
    output logic                       win_ready,
    input  logic                       win_ack,
    input  logic                       rd_req,
    input  logic [$clog2(WIN_LEN)-1:0] rd_idx,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_sample
`ifdef LPC_RING_OVR_EN
    ,
    output logic                       overrun
`endif
);

    localparam int AW = $clog2(DEPTH);          // RAM address width
    localparam int CW = $clog2(FRAME_LEN);      // in-frame sample counter width
    localparam int FW = $clog2(WIN_LEN + 1);    // fill counter width (0..WIN_LEN)
    localparam int IW = $clog2(WIN_LEN);        // rd_idx width
    localparam int SW = ((AW > IW) ? AW : IW) + 1;  // base+idx sum width

    localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] WIN_A      = AW'(WIN_LEN);
    localparam logic [AW-1:0] BACK_OFS   = AW'(DEPTH - WIN_LEN);
    localparam logic [CW-1:0] SUB_LAST   = CW'(SUB_LEN - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] FILL_MAX   = FW'(WIN_LEN);
    localparam logic [SW-1:0] DEPTH_S    = SW'(DEPTH);
    localparam logic [IW:0]   WIN_I      = (IW+1)'(WIN_LEN);

    // Sample storage. Not reset: stale entries are hidden by the fill count.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic [FW-1:0] fill;
    logic [AW-1:0] win_base;
    logic [FW-1:0] win_fill;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [AW-1:0] wptr_nxt;
    logic [FW-1:0] fill_nxt;
    logic [AW-1:0] base_nxt;
    logic          frame_evt;
    logic          sub_evt;

    always_comb begin
        // compare-and-clear wrap, no modulo hardware
        wptr_nxt  = (wptr == DEPTH_LAST) ? '0 : wptr + 1'b1;
        fill_nxt  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        // oldest sample of the window ending at the sample just written
        base_nxt  = (wptr_nxt >= WIN_A) ? (wptr_nxt - WIN_A)
                                        : (wptr_nxt + BACK_OFS);
        frame_evt = in_valid && (cnt == FRAME_LAST);
        sub_evt   = in_valid && ((cnt == SUB_LAST) || (cnt == FRAME_LAST));
    end

    always_ff @(posedge clock) begin
        if (in_valid) begin
            mem[wptr] <= in_sample;
        end
    end

    // ------------------------------------------------------------------
    // Read address: base + idx folded back into the ring with one subtract
    // ------------------------------------------------------------------
    logic [SW-1:0] addr_sum;
    logic [SW-1:0] addr_wrap;
    logic [AW-1:0] rd_addr;
    logic [IW:0]   idx_ext;
    logic [IW:0]   hole;
    logic          rd_zero;
    logic          rd_fire;
    logic          unused_addr_msb;

    always_comb begin
        addr_sum  = SW'(win_base) + SW'(rd_idx);
        addr_wrap = (addr_sum >= DEPTH_S) ? (addr_sum - DEPTH_S) : addr_sum;
        idx_ext   = {1'b0, rd_idx};
        // leading part of the window that was never written since reset
        hole      = WIN_I - (IW+1)'(win_fill);
        rd_zero   = (idx_ext >= WIN_I) || (idx_ext < hole);
        rd_fire   = rd_req && win_ready;
    end

    assign rd_addr         = addr_wrap[AW-1:0];
    assign unused_addr_msb = &{1'b0, addr_wrap[SW-1:AW]};

    // ------------------------------------------------------------------
    // Control, window latch and read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr       <= '0;
            cnt        <= '0;
            fill       <= '0;
            win_base   <= '0;
            win_fill   <= '0;
            win_ready  <= 1'b0;
            sub_done   <= 1'b0;
            frame_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_sample  <= '0;
        end else begin
            sub_done   <= sub_evt;
            frame_done <= frame_evt;

            if (in_valid) begin
                wptr <= wptr_nxt;
                cnt  <= (cnt == FRAME_LAST) ? '0 : cnt + 1'b1;
                fill <= fill_nxt;
            end

            if (frame_evt) begin
                win_base <= base_nxt;
                win_fill <= fill_nxt;
            end

            // A completing frame always wins over a release in the same cycle
            if (frame_evt) begin
                win_ready <= 1'b1;
            end else if (win_ack) begin
                win_ready <= 1'b0;
            end

            // Reads use the window as it stands before this edge
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_sample <= rd_zero ? '0 : mem[rd_addr];
            end
        end
    end

`ifdef LPC_RING_OVR_EN
    // Sticky: a new window overwrote one still held by the reader
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (frame_evt && win_ready && !win_ack) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lpc_ring_buf.sv
module tb_lpc_ring_buf;

    localparam int DATA_W    = 16;
    localparam int SUB_LEN   = 40;
    localparam int FRAME_LEN = 80;
    localparam int WIN_LEN   = 240;
    localparam int DEPTH     = 320;
    localparam int IW        = $clog2(WIN_LEN);

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_sample;
    logic              sub_done;
    logic              frame_done;
    logic              win_ready;
    logic              win_ack;
    logic              rd_req;
    logic [IW-1:0]     rd_idx;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_sample;
`ifdef LPC_RING_OVR_EN
    logic              overrun;
`endif

    lpc_ring_buf #(
        .DATA_W(DATA_W), .SUB_LEN(SUB_LEN), .FRAME_LEN(FRAME_LEN),
        .WIN_LEN(WIN_LEN), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_sample(in_sample),
        .sub_done(sub_done), .frame_done(frame_done),
        .win_ready(win_ready), .win_ack(win_ack),
        .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_sample(rd_sample)
`ifdef LPC_RING_OVR_EN
        , .overrun(overrun)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          sub;
        bit          frame;
        bit          ready;
        bit          ovr;
        bit          rdv;
        bit          chk_data;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: sample history and the reader-visible window
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] m_win[WIN_LEN];
    int                m_cnt;
    bit                m_ready;
    bit                m_ovr;
    int                next_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sub_done", 32'(sub_done), 32'(e.sub));
                chk("frame_done", 32'(frame_done), 32'(e.frame));
                chk("win_ready", 32'(win_ready), 32'(e.ready));
                chk("rd_valid", 32'(rd_valid), 32'(e.rdv));
                if (e.chk_data) chk("rd_sample", 32'(rd_sample), 32'(e.data));
`ifdef LPC_RING_OVR_EN
                chk("overrun", 32'(overrun), 32'(e.ovr));
`endif
            end
        end
    end

    // One clock edge: apply the model to the inputs sampled at that edge
    task automatic step();
        exp_t e;
        bit   fin;
        int   pad;
        @(posedge clock);
        e = '{default: 0};
        if (reset) begin
            hist.delete();
            foreach (m_win[i]) m_win[i] = '0;
            m_cnt = 0; m_ready = 0; m_ovr = 0;
            e.chk_data = 1;
            e.data = '0;
        end else begin
            if (rd_req && m_ready) begin
                e.rdv = 1;
                e.chk_data = 1;
                e.data = (int'(rd_idx) < WIN_LEN) ? m_win[rd_idx] : '0;
            end
            fin = 0;
            if (in_valid) begin
                hist.push_back(in_sample);
                if (hist.size() > WIN_LEN) void'(hist.pop_front());
                e.sub = (m_cnt == SUB_LEN-1) || (m_cnt == FRAME_LEN-1);
                fin = (m_cnt == FRAME_LEN-1);
                m_cnt = fin ? 0 : m_cnt + 1;
            end
            if (fin) begin
                pad = WIN_LEN - hist.size();
                for (int i = 0; i < WIN_LEN; i++)
                    m_win[i] = (i < pad) ? '0 : hist[i-pad];
                if (m_ready && !win_ack) m_ovr = 1;
                m_ready = 1;
            end else if (win_ack) begin
                m_ready = 0;
            end
            e.frame = fin;
            e.ready = m_ready;
            e.ovr   = m_ovr;
        end
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 0; win_ack = 0; rd_req = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    task automatic feed(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1;
            in_sample = seq ? DATA_W'(next_val) : DATA_W'($urandom);
            next_val++;
            step();
        end
        in_valid = 0;
    endtask

    task automatic ack();
        win_ack = 1; step(); win_ack = 0;
    endtask

    task automatic read_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_req = 1;
            rd_idx = IW'(i);
            step();
        end
        rd_req = 0;
    endtask

    // Single read with a literal expectation as well as the scoreboard check
    task automatic rd_direct(input string name, input int idx, input int exp);
        rd_req = 1; rd_idx = IW'(idx);
        step();
        rd_req = 0;
        chk(name, 32'(rd_sample), 32'(exp));
    endtask

    initial begin
        reset = 1; in_valid = 0; in_sample = '0; win_ack = 0;
        rd_req = 0; rd_idx = '0;
        m_cnt = 0; m_ready = 0; m_ovr = 0;
        @(negedge clock);
        step(); step();
        reset = 0;
        idle(2);

        // First frame of k+1 values, then a full back-to-back window read
        next_val = 1;
        rd_req = 1; rd_idx = 0;           // request while no window: ignored
        feed(FRAME_LEN, 1);
        rd_req = 0;
        idle(1);
        rd_direct("f1_idx0", 0, 0);
        rd_direct("f1_idx159", 159, 0);
        rd_direct("f1_idx160", 160, 1);
        rd_direct("f1_idx239", 239, 80);
        rd_direct("f1_idx250", 250, 0);
        read_range(0, WIN_LEN-1);
        idle(1);
        ack();
        ack();                            // ack while not ready is ignored

        // Three more acked frames; the 4th window spans the pointer wrap
        feed(FRAME_LEN, 1); ack();
        feed(FRAME_LEN, 1); ack();
        feed(FRAME_LEN, 1);
        rd_direct("f4_idx0", 0, 81);
        rd_direct("f4_idx239", 239, 320);
        feed(FRAME_LEN, 1);               // no ack: window replaced
        rd_direct("f5_idx239", 239, 400);
        rd_direct("f5_idx0", 0, 161);

        // Frame 2 completes without a release
        do_reset();
        next_val = 1;
        feed(FRAME_LEN, 1);
        feed(FRAME_LEN, 1);
        rd_direct("ovr_idx239", 239, 160);
        rd_direct("ovr_idx80", 80, 1);

        // Release coincides with frame completion
        do_reset();
        feed(FRAME_LEN, 0);
        feed(FRAME_LEN-1, 0);
        win_ack = 1;
        feed(1, 0);
        win_ack = 0;
        idle(1);
        chk("ack_same_ready", 32'(win_ready), 32'd1);

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sample = DATA_W'($urandom);
            win_ack   = ($urandom_range(0, 15) == 0);
            rd_req    = $urandom_range(0, 1) == 1;
            rd_idx    = IW'($urandom_range(0, (1 << IW) - 1));
            step();
        end
        idle(1);

        // Reset in mid-frame and mid-read, then a fresh frame
        do_reset();
        next_val = 1;
        feed(FRAME_LEN, 1);
        feed(36, 0);
        rd_req = 1; rd_idx = 200; in_valid = 1; in_sample = 16'h1234;
        reset = 1;
        step();
        reset = 0; rd_req = 0; in_valid = 0;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_sample", 32'(rd_sample), 32'd0);
        chk("rst_win_ready", 32'(win_ready), 32'd0);
        next_val = 1;
        feed(FRAME_LEN-1, 1);
        chk("rst_no_early_frame", 32'(win_ready), 32'd0);
        feed(1, 1);
        chk("rst_frame_after_80", 32'(frame_done), 32'd1);
        rd_direct("rst_idx239", 239, 80);
        rd_direct("rst_idx159", 159, 0);
        idle(2);

        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
